// File: rtl/tree_spawn_pkg.sv
// Shared types and screen constants for the tree spawn scheduler and its
// trajectory blocks.
package tree_spawn_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GAP = 2'd1,
      SPAWN    = 2'd2
   } spawn_state_t;

   localparam int         SCREEN_WIDTH = 640;
   localparam int         IMAGE_WIDTH  = 32;
   localparam logic [1:0] MAX_SPEED    = 2'd3;
   localparam int         GAP_W        = 16;
   localparam int         FRAME_W      = 16;

   // Spawn X is X_MIN plus twice the random byte. For a large X_MIN the result
   // is held back so that the whole tree image stays on screen.
   function automatic logic [10:0] spawn_x(input logic [10:0] x_min,
                                           input logic [7:0]  rnd);
      logic [10:0] x;
      x = x_min + {2'b00, rnd, 1'b0};
      if (x > 11'(SCREEN_WIDTH - IMAGE_WIDTH))
         x = 11'(SCREEN_WIDTH - IMAGE_WIDTH);
      return x;
   endfunction

endpackage

// File: rtl/tree_spawn_ctrl_if.sv
// Bundle between the spawn scheduler (slave) and the game/trajectory side (master).
// Optional macro TREE_SPAWN_STATS_EN adds the spawn_total/hit_total counters.
interface tree_spawn_ctrl_if #(parameter int NUM_SLOTS = 4);

   logic                 startOfFrame;
   logic                 enable;
   logic [7:0]           random;
   logic [NUM_SLOTS-1:0] slot_collision;
   logic [NUM_SLOTS-1:0] slot_offscreen;
   // deploy is the valid for initial_x. There is no ready or backpressure, so
   // a trajectory block must take the deploy pulse in the cycle it appears.
   logic [NUM_SLOTS-1:0] deploy;
   logic [NUM_SLOTS-1:0] remove;
   logic [10:0]          initial_x;
   logic [1:0]           speed;
   logic [NUM_SLOTS-1:0] active;
`ifdef TREE_SPAWN_STATS_EN
   logic [15:0]          spawn_total;
   logic [15:0]          hit_total;
`endif

   modport master (
      output startOfFrame, enable, random, slot_collision, slot_offscreen,
      input  deploy, remove, initial_x, speed, active
`ifdef TREE_SPAWN_STATS_EN
      , input spawn_total, hit_total
`endif
   );

   modport slave (
      input  startOfFrame, enable, random, slot_collision, slot_offscreen,
      output deploy, remove, initial_x, speed, active
`ifdef TREE_SPAWN_STATS_EN
      , output spawn_total, hit_total
`endif
   );

endinterface

// File: rtl/tree_slot_picker.sv
// Combinational encoder that returns the lowest-index free tree slot.
module tree_slot_picker #(
   parameter int NUM_SLOTS = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_SLOTS-1:0] free,
   output logic                 found,
   output logic [IDX_W-1:0]     idx
);

   // Scan from the top down so that the lowest free index is written last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free[i]) begin
            found = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/tree_spawn_ctrl.sv
// Spawn scheduler for the tree slots: frame-gap spacing, speed levels, slot freeing.
// Optional macro TREE_SPAWN_STATS_EN adds saturating spawn/hit counters.
module tree_spawn_ctrl
   import tree_spawn_pkg::*;
#(
   parameter int         NUM_SLOTS      = 4,
   parameter int         MIN_GAP_FRAMES = 20,
   parameter logic [7:0] GAP_MASK       = 8'h3F,
   parameter int         LEVEL_FRAMES   = 900,
   parameter int         X_MIN          = 32
) (
   input  logic               clk,
   input  logic               resetN,
   tree_spawn_ctrl_if.slave   bus,
   output spawn_state_t       state_dbg
);

   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [FRAME_W-1:0] LEVEL_LAST = FRAME_W'(LEVEL_FRAMES - 1);

   spawn_state_t         state_q, state_n;
   logic [GAP_W-1:0]     gap_q, gap_n, gap_load;
   logic [FRAME_W-1:0]   frame_q, frame_n;
   logic [1:0]           speed_q, speed_n;
   logic [NUM_SLOTS-1:0] active_q, active_n;
   logic [NUM_SLOTS-1:0] deploy_q, deploy_n;
   logic [NUM_SLOTS-1:0] remove_q, remove_n;
   logic [NUM_SLOTS-1:0] hits;
   logic [10:0]          x_q, x_n;
   logic                 found;
   logic [IDX_W-1:0]     idx;

   // Only slots that were already free at the start of this cycle can be
   // picked, so a slot freed in this cycle waits one cycle before redeploy.
   tree_slot_picker #(.NUM_SLOTS(NUM_SLOTS), .IDX_W(IDX_W)) u_picker (
      .free  (~active_q),
      .found (found),
      .idx   (idx)
   );

   assign gap_load = GAP_W'(MIN_GAP_FRAMES) + GAP_W'(bus.random & GAP_MASK);
   assign hits     = (bus.slot_collision | bus.slot_offscreen) & active_q;

   always_comb begin
      state_n  = state_q;
      gap_n    = gap_q;
      frame_n  = frame_q;
      speed_n  = speed_q;
      active_n = active_q;
      deploy_n = '0;
      remove_n = '0;
      x_n      = x_q;
      if (!bus.enable) begin
         remove_n = active_q;
         active_n = '0;
         speed_n  = 2'd0;
         frame_n  = '0;
         gap_n    = '0;
         state_n  = IDLE;
      end else begin
         if (bus.startOfFrame) begin
            if (frame_q == LEVEL_LAST) begin
               frame_n = '0;
               if (speed_q != MAX_SPEED)
                  speed_n = speed_q + 2'd1;
            end else begin
               frame_n = frame_q + FRAME_W'(1);
            end
         end
         case (state_q)
            IDLE: begin
               state_n = WAIT_GAP;
               gap_n   = gap_load;
            end
            WAIT_GAP: begin
               if (bus.startOfFrame) begin
                  if (gap_q <= GAP_W'(1)) begin
                     gap_n   = '0;
                     state_n = SPAWN;
                  end else begin
                     gap_n = gap_q - GAP_W'(1);
                  end
               end
            end
            SPAWN: begin
               if (found) begin
                  deploy_n = NUM_SLOTS'(1) << idx;
                  x_n      = spawn_x(11'(X_MIN), bus.random);
                  gap_n    = gap_load;
                  state_n  = WAIT_GAP;
               end
            end
            default: state_n = IDLE;
         endcase
         // Deploy only targets inactive slots and hits only active ones, so the
         // two masks never overlap.
         if (state_q != IDLE) begin
            remove_n = hits;
            active_n = (active_q & ~hits) | deploy_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q  <= IDLE;
         gap_q    <= '0;
         frame_q  <= '0;
         speed_q  <= 2'd0;
         active_q <= '0;
         deploy_q <= '0;
         remove_q <= '0;
         x_q      <= '0;
      end else begin
         state_q  <= state_n;
         gap_q    <= gap_n;
         frame_q  <= frame_n;
         speed_q  <= speed_n;
         active_q <= active_n;
         deploy_q <= deploy_n;
         remove_q <= remove_n;
         x_q      <= x_n;
      end
   end

   assign bus.deploy    = deploy_q;
   assign bus.remove    = remove_q;
   assign bus.initial_x = x_q;
   assign bus.speed     = speed_q;
   assign bus.active    = active_q;
   assign state_dbg     = state_q;

`ifdef TREE_SPAWN_STATS_EN
   logic [15:0] spawn_total_q, hit_total_q;
   logic [3:0]  hit_cnt;
   logic [16:0] hit_sum;

   // Only collisions count as hits; enable-fall clears are not hits.
   always_comb begin
      hit_cnt = 4'd0;
      if (bus.enable && state_q != IDLE) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.slot_collision[i] && active_q[i])
               hit_cnt = hit_cnt + 4'd1;
         end
      end
   end

   assign hit_sum = {1'b0, hit_total_q} + 17'(hit_cnt);

   always_ff @(posedge clk) begin
      if (!resetN) begin
         spawn_total_q <= '0;
         hit_total_q   <= '0;
      end else begin
         if (deploy_n != '0 && spawn_total_q != 16'hFFFF)
            spawn_total_q <= spawn_total_q + 16'd1;
         hit_total_q <= hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
      end
   end

   assign bus.spawn_total = spawn_total_q;
   assign bus.hit_total   = hit_total_q;
`endif

endmodule

// File: tb/tb_tree_spawn_ctrl.sv
// Directed bench for tree_spawn_ctrl: a driver issues frames and slot events,
// and a negedge monitor checks deploy/remove pulses against expected queues.
module tb_tree_spawn_ctrl;
   import tree_spawn_pkg::*;

   logic         clk;
   logic         resetN;
   spawn_state_t state_dbg;

   tree_spawn_ctrl_if #(.NUM_SLOTS(4)) bus ();

   tree_spawn_ctrl #(.NUM_SLOTS(4)) dut (
      .clk       (clk),
      .resetN    (resetN),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int dep_seen = 0;

   logic [14:0] exp_dep_q[$];  // {deploy, initial_x}
   logic [3:0]  exp_rem_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      repeat (3) tick();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   // Monitor: every deploy/remove pulse must match the head of its queue.
   always @(negedge clk) begin
      logic [14:0] ed;
      logic [3:0]  er;
      if (resetN === 1'b1) begin
         if (bus.deploy != 4'b0000) begin
            dep_seen++;
            if (exp_dep_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL deploy_unexpected: got deploy=%b x=%0d, required no deploy",
                        bus.deploy, bus.initial_x);
            end else begin
               ed = exp_dep_q.pop_front();
               chk("deploy_slot", 32'(bus.deploy), 32'(ed[14:11]));
               chk("deploy_x", 32'(bus.initial_x), 32'(ed[10:0]));
            end
         end
         if (bus.remove != 4'b0000) begin
            if (exp_rem_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL remove_unexpected: got remove=%b, required no remove", bus.remove);
            end else begin
               er = exp_rem_q.pop_front();
               chk("remove_mask", 32'(bus.remove), 32'(er));
            end
         end
      end
   end

   initial begin
      resetN             = 1'b0;
      bus.startOfFrame   = 1'b0;
      bus.enable         = 1'b0;
      bus.random         = 8'h00;
      bus.slot_collision = 4'b0000;
      bus.slot_offscreen = 4'b0000;
      repeat (3) tick();

      // Reset state
      chk("rst_deploy", 32'(bus.deploy), 0);
      chk("rst_remove", 32'(bus.remove), 0);
      chk("rst_x", 32'(bus.initial_x), 0);
      chk("rst_speed", 32'(bus.speed), 0);
      chk("rst_active", 32'(bus.active), 0);
      chk("rst_state", 32'(state_dbg), 32'(IDLE));

      // First deploy after exactly 25 frames with random=5
      resetN     = 1'b1;
      bus.enable = 1'b1;
      bus.random = 8'h05;
      tick();
      chk("state_wait", 32'(state_dbg), 32'(WAIT_GAP));
      frames(24);
      exp_dep_q.push_back({4'b0001, 11'd42});
      frame();
      chk("dep_count_1", dep_seen, 1);

      // Collision on an inactive slot is ignored
      bus.slot_collision = 4'b0010;
      tick();
      bus.slot_collision = 4'b0000;
      tick();
      chk("inactive_hit_active", 32'(bus.active), 32'h1);

      // random=FF: x=542, then gap of 83 frames
      bus.random = 8'hFF;
      frames(24);
      exp_dep_q.push_back({4'b0010, 11'd542});
      frame();
      chk("dep_count_2", dep_seen, 2);
      bus.random = 8'h00;
      frames(82);
      chk("dep_count_83_early", dep_seen, 2);
      exp_dep_q.push_back({4'b0100, 11'd32});
      frame();
      chk("dep_count_3", dep_seen, 3);

      // Fill the last slot, then stall in SPAWN with all slots held
      frames(19);
      exp_dep_q.push_back({4'b1000, 11'd32});
      frame();
      chk("dep_count_4", dep_seen, 4);
      chk("active_full", 32'(bus.active), 32'hF);
      frames(20);
      chk("stall_state", 32'(state_dbg), 32'(SPAWN));
      chk("stall_dep_count", dep_seen, 4);

      // Offscreen frees slot 2; it is redeployed one cycle later
      bus.random = 8'h10;
      exp_rem_q.push_back(4'b0100);
      exp_dep_q.push_back({4'b0100, 11'd64});
      bus.slot_offscreen = 4'b0100;
      tick();
      bus.slot_offscreen = 4'b0000;
      chk("free_remove", 32'(bus.remove), 32'h4);
      chk("free_no_deploy", 32'(bus.deploy), 0);
      tick();
      chk("redeploy", 32'(bus.deploy), 32'h4);
      tick();
      chk("dep_count_5", dep_seen, 5);

      // Simultaneous collision and offscreen on two slots
      exp_rem_q.push_back(4'b1001);
      bus.slot_collision = 4'b0001;
      bus.slot_offscreen = 4'b1000;
      tick();
      bus.slot_collision = 4'b0000;
      bus.slot_offscreen = 4'b0000;
      tick();
      chk("multi_remove_active", 32'(bus.active), 32'h6);

      // Enable drop clears live trees
      exp_rem_q.push_back(4'b0110);
      bus.enable = 1'b0;
      repeat (2) tick();
      chk("clear_active", 32'(bus.active), 0);
      chk("clear_state", 32'(state_dbg), 32'(IDLE));
`ifdef TREE_SPAWN_STATS_EN
      chk("stats_spawn_5", 32'(bus.spawn_total), 5);
      chk("stats_hit_1", 32'(bus.hit_total), 1);
`endif

      // Speed levels over 3600 frames; four deploys at 20-frame gaps fill the slots
      bus.random = 8'h00;
      exp_dep_q.push_back({4'b0001, 11'd32});
      exp_dep_q.push_back({4'b0010, 11'd32});
      exp_dep_q.push_back({4'b0100, 11'd32});
      exp_dep_q.push_back({4'b1000, 11'd32});
      bus.enable = 1'b1;
      tick();
      for (int f = 1; f <= 3600; f++) begin
         frame();
         if (f == 899)  chk("speed_f899", 32'(bus.speed), 0);
         if (f == 900)  chk("speed_f900", 32'(bus.speed), 1);
         if (f == 1800) chk("speed_f1800", 32'(bus.speed), 2);
         if (f == 2700) chk("speed_f2700", 32'(bus.speed), 3);
         if (f == 3600) chk("speed_f3600", 32'(bus.speed), 3);
      end
      chk("dep_count_9", dep_seen, 9);
      chk("active_full_2", 32'(bus.active), 32'hF);

      // active=1011 then enable drop: remove=1011, no deploy into freed slot 2
      exp_rem_q.push_back(4'b0100);
      exp_rem_q.push_back(4'b1011);
      bus.slot_collision = 4'b0100;
      tick();
      bus.slot_collision = 4'b0000;
      bus.enable         = 1'b0;
      chk("pre_drop_active", 32'(bus.active), 32'hB);
      tick();
      chk("drop_remove", 32'(bus.remove), 32'hB);
      tick();
      chk("drop_active", 32'(bus.active), 0);
      chk("drop_speed", 32'(bus.speed), 0);
      chk("drop_state", 32'(state_dbg), 32'(IDLE));
      chk("drop_remove_done", 32'(bus.remove), 0);
      chk("drop_no_deploy", dep_seen, 9);
`ifdef TREE_SPAWN_STATS_EN
      chk("stats_spawn_9", 32'(bus.spawn_total), 9);
      chk("stats_hit_2", 32'(bus.hit_total), 2);
`endif

      repeat (3) tick();
      chk("dep_queue_empty", exp_dep_q.size(), 0);
      chk("rem_queue_empty", exp_rem_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
